// File: rtl/iob_cache_axi_ram_responder_if.sv
// AXI4 bus bundle between the cache back-end master and the RAM responder.
// Every channel moves a beat on a rising edge where valid && ready; valid never waits on ready.
interface iob_cache_axi_ram_responder_if #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
);
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [AXI_LEN_W-1:0]    awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [AXI_LEN_W-1:0]    arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/iob_cache_axi_ram_responder.sv
// AXI4 responder over a word-addressed RAM with independent read and write burst FSMs.
// Optional IOB_CACHE_AXI_RAM_STALL_EN inserts bubbles between data beats and before the B response.
module iob_cache_axi_ram_responder #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  iob_cache_axi_ram_responder_if.slave  axi,
  output logic                          r_state_dbg,
  output logic [1:0]                    w_state_dbg
);
  localparam int NBYTES      = AXI_DATA_W / 8;
  localparam int BE_NBYTES_W = $clog2(NBYTES);

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_GAP, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [AXI_DATA_W-1:0] mem [2**MEM_ADDR_W];

  logic                  live;  // holds the ready outputs low until the first edge after reset
  logic [AXI_ID_W-1:0]   r_id, w_id;
  logic [MEM_ADDR_W-1:0] r_idx, w_idx;
  logic [AXI_LEN_W-1:0]  r_len, w_len, r_beat, w_beat;
  logic [1:0]            b_resp;
  logic                  ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid;
  logic                  r_gate, w_gate;
  logic                  ar_hs, r_hs, aw_hs, w_hs, w_end;

  assign ar_hs = axi.arvalid && ar_ready;
  assign r_hs  = r_valid && axi.rready;
  assign aw_hs = axi.awvalid && aw_ready;
  assign w_hs  = axi.wvalid && w_ready;
  assign w_end = axi.wlast || (w_beat == w_len);

`ifdef IOB_CACHE_AXI_RAM_STALL_EN
  logic r_tog, w_tog;
  // Toggle drops for one cycle after each accepted beat, forcing a bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tog <= 1'b0;
      w_tog <= 1'b0;
    end else begin
      r_tog <= (r_state == R_IDLE) ? 1'b1 : !r_hs;
      w_tog <= (w_state == W_IDLE) ? 1'b1 : !w_hs;
    end
  end
  assign r_gate = r_tog;
  assign w_gate = w_tog;
`else
  assign r_gate = 1'b1;
  assign w_gate = 1'b1;
`endif

  always_comb begin
    r_next   = r_state;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_last   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready = live;
        if (axi.arvalid && live) r_next = R_DATA;
      end
      R_DATA: begin
        r_valid = r_gate;
        r_last  = r_gate && (r_beat == r_len);
        if (r_valid && axi.rready && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = live;
        if (axi.awvalid && live) w_next = W_DATA;
      end
      W_DATA: begin
        w_ready = w_gate;
        if (w_ready && axi.wvalid && w_end) begin
`ifdef IOB_CACHE_AXI_RAM_STALL_EN
          w_next = W_GAP;
`else
          w_next = W_RESP;
`endif
        end
      end
      W_GAP:  w_next = W_RESP;
      W_RESP: begin
        b_valid = 1'b1;
        if (axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      live    <= 1'b0;
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      b_resp  <= '0;
    end else begin
      live    <= 1'b1;
      r_state <= r_next;
      w_state <= w_next;
      if (ar_hs) begin
        r_id   <= axi.arid;
        r_idx  <= axi.araddr[BE_NBYTES_W +: MEM_ADDR_W];
        r_len  <= axi.arlen;
        r_beat <= '0;
      end else if (r_hs) begin
        r_idx  <= r_idx + MEM_ADDR_W'(1);
        r_beat <= r_beat + AXI_LEN_W'(1);
      end
      if (aw_hs) begin
        w_id   <= axi.awid;
        w_idx  <= axi.awaddr[BE_NBYTES_W +: MEM_ADDR_W];
        w_len  <= axi.awlen;
        w_beat <= '0;
      end else if (w_hs) begin
        w_idx  <= w_idx + MEM_ADDR_W'(1);
        w_beat <= w_beat + AXI_LEN_W'(1);
        // A burst ending on a mismatched wlast/length is still written, but flagged.
        if (w_end) b_resp <= (axi.wlast && (w_beat == w_len)) ? 2'b00 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  assign axi.arready = ar_ready;
  assign axi.rvalid  = r_valid;
  assign axi.rlast   = r_last;
  assign axi.rid     = r_id;
  assign axi.rresp   = 2'b00;
  assign axi.rdata   = r_valid ? mem[r_idx] : '0;
  assign axi.awready = aw_ready;
  assign axi.wready  = w_ready;
  assign axi.bvalid  = b_valid;
  assign axi.bid     = w_id;
  assign axi.bresp   = b_resp;

  assign r_state_dbg = r_state;
  assign w_state_dbg = w_state;

  logic unused_ok;
  assign unused_ok = ^{axi.awaddr, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                       axi.awprot, axi.awqos, axi.araddr, axi.arsize, axi.arburst,
                       axi.arlock, axi.arcache, axi.arprot, axi.arqos};
endmodule
